// File: rtl/gpioemu_mulpop.sv
// gpioemu_mulpop: bus-mapped sequential shift-add multiplier with popcount of the result
module gpioemu_mulpop #(
  parameter int ARG_W = 24,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16,
  parameter logic [15:0] ADDR_A1 = 16'h037F,
  parameter logic [15:0] ADDR_A2 = 16'h0388,
  parameter logic [15:0] ADDR_W  = 16'h0390,
  parameter logic [15:0] ADDR_L  = 16'h0398,
  parameter logic [15:0] ADDR_B  = 16'h03A0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);
  localparam int PW = 2 * ARG_W;
  localparam int LW = $clog2(OUT_W + 1);
  localparam int CW = $clog2(ARG_W + 1);
  typedef enum logic [1:0] {IDLE, MULT, COUNT} state_t;
  state_t state, state_nx;
  logic [ARG_W-1:0] a1, a2, mplier;
  logic [PW-1:0] prod, mcand;
  logic [CW-1:0] cnt;
  logic [LW-1:0] l_reg, pc;
  logic [CNT_W-1:0] op_count;
  logic [31:0] gpio_in_s, rd_data;
  logic done, valid, err, ready, wr_b, start, clr_err, unused_bits;
  assign ready = state == IDLE;
  assign wr_b = swr && saddress == ADDR_B;
  assign start = wr_b && sdata_in[0];
  assign clr_err = wr_b && sdata_in[3];
  assign gpio_out = 32'(op_count);
  assign gpio_in_s_insp = gpio_in_s;
  assign unused_bits = ^sdata_in;
  always_comb begin
    state_nx = state == IDLE ? (start ? MULT : IDLE) :
               state == MULT ? (cnt == '0 ? COUNT : MULT) : IDLE;
  end
  always_comb begin
    pc = '0;
    for (int i = 0; i < OUT_W; i++) pc = pc + LW'(prod[i]);
  end
  always_comb begin
    rd_data = saddress == ADDR_A1 ? 32'(a1) :
              saddress == ADDR_A2 ? 32'(a2) :
              saddress == ADDR_W  ? (done ? 32'(prod[OUT_W-1:0]) : '0) :
              saddress == ADDR_L  ? (done ? 32'(l_reg) : '0) :
              saddress == ADDR_B  ? {28'b0, err, done, ready, valid} : '0;
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1 <= '0;
      a2 <= '0;
      mplier <= '0;
      mcand <= '0;
      prod <= '0;
      cnt <= '0;
      l_reg <= '0;
      op_count <= '0;
      gpio_in_s <= '0;
      sdata_out <= '0;
      done <= 1'b0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      if (swr && saddress == ADDR_A1) a1 <= sdata_in[ARG_W-1:0];
      if (swr && saddress == ADDR_A2) a2 <= sdata_in[ARG_W-1:0];
      if (srd) sdata_out <= rd_data;
      if (gpio_latch) gpio_in_s <= gpio_in;
      // a busy start wins over a simultaneous clear so it is never lost
      err <= (err && !clr_err) || (start && !ready);
      if (start && ready) begin
        mcand <= PW'(a1);
        mplier <= a2;
        prod <= '0;
        cnt <= CW'(ARG_W - 1);
        done <= 1'b0;
        valid <= 1'b0;
      end
      if (state == MULT) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt - CW'(1);
      end
      if (state == COUNT) begin
        l_reg <= pc;
        valid <= (prod >> OUT_W) == '0;
        done <= 1'b1;
        op_count <= op_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/gpioemu_mulpop.md
# gpioemu_mulpop

Parametrised bus-mapped multiply/popcount coprocessor for the GPIO emulator. It is the next generation of the fixed 24-bit multiplier peripheral. Two operands of configurable width are written over the simple address/strobe bus. A start command runs a sequential shift-add multiply, followed by a population count of the result. Status, result, bit count and an operation counter are exposed through the bus and the `gpio_out` pins, and a `gpio_in` latch is kept for inspection.

## Interface
- ARG_W, 24, operand width in bits; 1..32
- OUT_W, 32, width of the readable result W; ARG_W ≤ OUT_W ≤ min(2·ARG_W, 32)
- CNT_W, 16, operation counter width; 1..32
- ADDR_A1 / ADDR_A2 / ADDR_W / ADDR_L / ADDR_B, 16'h037F / 16'h0388 / 16'h0390 / 16'h0398 / 16'h03A0, register addresses
- clk  in  1  sole clock; all state is updated on its rising edge
- n_reset  in  1  asynchronous, active-low reset
- saddress  in  16  register address, sampled with srd/swr
- srd  in  1  read strobe, one clk cycle high per access
- swr  in  1  write strobe, one clk cycle high per access
- sdata_in  in  32  write data
- sdata_out  out  32  registered read data
- gpio_in  in  32  external input bus
- gpio_latch  in  1  when high at a clk edge, gpio_in is captured
- gpio_out  out  32  {zeros, op_count[CNT_W-1:0]}
- gpio_in_s_insp  out  32  last captured gpio_in value

## Operation
- Registers:
  - A1 and A2 are read/write and take sdata_in[ARG_W-1:0]; they read back zero-extended.
  - W is read-only; it returns prod[OUT_W-1:0] when done=1, otherwise 0.
  - L is read-only; it returns the popcount of W zero-extended when done=1, otherwise 0.
  - B layout: bit0 valid (prod[2·ARG_W-1:OUT_W]==0), bit1 ready (state IDLE), bit2 done, bit3 err.
  - Reads of any other address return 0.
- B write:
  - sdata_in[0]=1 is a start.
  - sdata_in[3]=1 clears err.
  - Other bits are ignored.
- Start in IDLE:
  - A1 and A2 are copied into shadow operands.
  - prod is cleared; done and valid are cleared.
  - State goes to MULT.
- Start outside IDLE: ignored; err is set (sticky). The running operation is unaffected.
- Writes to A1/A2 while busy are accepted. They affect only the next start.
- FSM:
  - IDLE: waits for start.
  - MULT: runs ARG_W cycles. Cycle i adds (shadowA1 << i) to prod when shadowA2[i]=1. prod is 2·ARG_W bits with no truncation.
  - COUNT: one cycle. Computes popcount(prod[OUT_W-1:0]) into L (width $clog2(OUT_W+1)) and computes valid.
  - COUNT → IDLE: done=1 and op_count increments. op_count wraps modulo 2^CNT_W.
- gpio_latch=1 at an edge copies gpio_in into gpio_in_s. It is independent of the FSM.

## Timing
- Reset values:
  - sdata_out=0, gpio_out=0, gpio_in_s_insp=0.
  - A1, A2, prod, L and op_count are 0.
  - State is IDLE; B reads 4'b0010.
- Reset asserted mid-operation clears everything immediately and asynchronously. No result is produced and op_count is not incremented.
- Reads: sdata_out is updated at the clk edge where srd=1 (valid from the next cycle) and holds until the next read.
- Writes take effect at the clk edge where swr=1.
- srd and swr high in the same cycle to the same address: the read returns the value from before the write.
- Latency: start at edge E0; MULT runs E1..E_ARG_W; COUNT at E_ARG_W+1. done, ready and op_count update at E_ARG_W+1, visible from edge E_ARG_W+2 (26 cycles for ARG_W=24).
- A start in the same cycle that COUNT completes is still busy: it sets err and is not queued.
- A start in IDLE with done=1 clears done in the same edge. W and L read 0 until the new completion.

## Test plan
- Reset, then write A1=3, A2=5, write B=1, wait 26 cycles → B reads 4'b0111, W=15, L=4, gpio_out=1.
- A1=A2=24'hFFFFFF, start → W=32'hFE000001, valid=0, L=8, B=4'b0110.
- Start, then a second start at cycle 5 → B bit3=1 and the first result is correct. Then write B=4'h8 → err cleared.
- Pull n_reset low at cycle 10 of an operation → all outputs 0 immediately, and B=4'b0010 after release.
- ARG_W=8, OUT_W=16, CNT_W=2: A1=A2=8'hFF → W=16'hFE01, valid=1, L=8, latency 10 cycles. After 4 operations gpio_out=0 (counter wrap).
- Pulse gpio_latch with gpio_in=32'hA5A5_0001, then change gpio_in → gpio_in_s_insp holds 32'hA5A5_0001. A read at address 16'h0000 returns 0.
